// File: rtl/divmmc_automap.sv
// DivMMC automap / paging controller.
// Decodes control port 0xE3, follows automap entry and exit on M1 opcode
// fetches and drives the overlay select outputs for 0x0000-0x3FFF.
// Optional build macro DIVMMC_NMI_EN: adds the NMI button latch. With it,
// the 0x0066 entry point only maps while an NMI is pending.
module divmmc_automap #(
  parameter int BANK_BITS = 4
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 enable,
  input  logic                 nWR,
  input  logic                 nRD,
  input  logic                 nMREQ,
  input  logic                 nIORQ,
  input  logic                 nM1,
  input  logic [15:0]          addr,
  input  logic [7:0]           din,
  input  logic                 nmi_button,
  output logic                 active,
  output logic                 rom_sel,
  output logic                 ram_sel,
  output logic [BANK_BITS-1:0] ram_bank,
  output logic                 wr_protect,
  output logic                 nmi_out
);

  typedef enum logic [1:0] {UNMAPPED, MAP_PEND, MAPPED, UNMAP_PEND} state_t;

  state_t                 state, state_next;
  logic                   conmem, mapram;
  logic [BANK_BITS-1:0]   bank;
  logic                   io_we_d, fetch_d, nm1_d;
  logic                   paging_on, io_we, fetch;
  logic                   io_we_edge, fetch_edge, fetch_end;
  logic                   is_entry, is_instant, is_exit, nmi_gate, automap;
  logic                   unused_bits;

  assign paging_on  = enable & (mode == 2'b01);
  assign io_we      = ~nIORQ & ~nWR & nM1 & (addr[7:0] == 8'hE3) & paging_on;
  assign fetch      = ~nM1 & ~nMREQ & ~nRD;
  assign io_we_edge = io_we & ~io_we_d;
  assign fetch_edge = fetch & ~fetch_d;
  assign fetch_end  = nM1 & ~nm1_d;

  assign is_instant = (addr[15:8] == 8'h3D);
  assign is_exit    = (addr[15:3] == 13'h03FF);
  assign is_entry   = (addr == 16'h0000) | (addr == 16'h0008) | (addr == 16'h0038) |
                      (addr == 16'h04C6) | (addr == 16'h0562) |
                      ((addr == 16'h0066) & nmi_gate);

  // Edge-detect history; follows the bus even in reset so a strobe held
  // across reset is not seen as a new edge afterwards.
  always_ff @(posedge clk_sys) begin
    io_we_d <= io_we;
    fetch_d <= fetch;
    nm1_d   <= nM1;
  end

  // Port 0xE3 control register; mapram is sticky until reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      conmem <= 1'b0;
      mapram <= 1'b0;
      bank   <= '0;
    end else if (io_we_edge) begin
      conmem <= din[7];
      mapram <= mapram | din[6];
      bank   <= din[BANK_BITS-1:0];
    end
  end

`ifdef DIVMMC_NMI_EN
  logic nmi_pend, nmi_btn_d;

  // NMI latch: button edge sets, the 0x0066 fetch consumes it.
  always_ff @(posedge clk_sys) begin
    nmi_btn_d <= nmi_button;
    if (reset)
      nmi_pend <= 1'b0;
    else if (nmi_button & ~nmi_btn_d)
      nmi_pend <= 1'b1;
    else if (fetch_edge & paging_on & (addr == 16'h0066))
      nmi_pend <= 1'b0;
  end

  assign nmi_gate = nmi_pend;
  assign nmi_out  = nmi_pend;
`else
  assign nmi_gate = 1'b1;
  assign nmi_out  = 1'b0;
`endif

  assign unused_bits = ^{nmi_button, din};

  // Automap state register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= UNMAPPED;
    else       state <= state_next;
  end

  // Automap transitions; leaving DivMMC mode drops any mapping or pending step.
  always_comb begin
    state_next = state;
    if (!paging_on) begin
      state_next = UNMAPPED;
    end else begin
      case (state)
        UNMAPPED: begin
          if (fetch_edge & is_instant)    state_next = MAPPED;
          else if (fetch_edge & is_entry) state_next = MAP_PEND;
        end
        MAP_PEND: begin
          if (fetch_edge & is_instant) state_next = MAPPED;
          else if (fetch_end)          state_next = MAPPED;
        end
        MAPPED: begin
          if (fetch_edge & is_exit) state_next = UNMAP_PEND;
        end
        UNMAP_PEND: begin
          if (fetch_end) state_next = UNMAPPED;
        end
        default: state_next = UNMAPPED;
      endcase
    end
  end

  assign automap = (state == MAPPED) | (state == UNMAP_PEND);
  assign active  = paging_on & (conmem | automap);

  // Overlay decode for the current access in the low 16K.
  always_comb begin
    rom_sel    = 1'b0;
    ram_sel    = 1'b0;
    ram_bank   = '0;
    wr_protect = 1'b0;
    if (active && addr[15:14] == 2'b00) begin
      if (!addr[13]) begin
        if (conmem) begin
          rom_sel = 1'b1;
        end else if (!mapram) begin
          rom_sel    = 1'b1;
          wr_protect = 1'b1;
        end else begin
          ram_sel    = 1'b1;
          ram_bank   = BANK_BITS'(3);
          wr_protect = 1'b1;
        end
      end else begin
        ram_sel    = 1'b1;
        ram_bank   = bank;
        wr_protect = ~conmem & mapram & (bank == BANK_BITS'(3));
      end
    end
  end

endmodule

// File: tb/tb_divmmc_automap.sv
// Self-checking bench for divmmc_automap: directed steps then random traffic
// compared against a rule-level model of the paging behaviour.
module tb_divmmc_automap;

  logic        clk_sys = 1'b0;
  logic        reset, enable, nWR, nRD, nMREQ, nIORQ, nM1, nmi_button;
  logic [1:0]  mode;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        active, rom_sel, ram_sel, wr_protect, nmi_out;
  logic [3:0]  ram_bank;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // model of the paging rules
  logic        m_conmem, m_mapram, m_automap, m_nmi;
  logic [3:0]  m_bank;
  int          m_pend;   // +1 map at fetch end, -1 unmap at fetch end, 0 none

  logic [15:0] entries [6] = '{16'h0000, 16'h0008, 16'h0038, 16'h0066, 16'h04C6, 16'h0562};

  divmmc_automap #(.BANK_BITS(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .mode(mode), .enable(enable),
    .nWR(nWR), .nRD(nRD), .nMREQ(nMREQ), .nIORQ(nIORQ), .nM1(nM1),
    .addr(addr), .din(din), .nmi_button(nmi_button),
    .active(active), .rom_sel(rom_sel), .ram_sel(ram_sel), .ram_bank(ram_bank),
    .wr_protect(wr_protect), .nmi_out(nmi_out)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic en_now();
    return enable && mode == 2'b01;
  endfunction

  function automatic logic [8:0] exp_out(input logic [15:0] a);
    logic act, rs, ms, wp;
    logic [3:0] bk;
    act = en_now() && (m_conmem || m_automap);
    rs = 0; ms = 0; wp = 0; bk = 0;
    if (act && a < 16'h4000) begin
      if (a < 16'h2000) begin
        if (m_conmem) rs = 1;
        else if (!m_mapram) begin rs = 1; wp = 1; end
        else begin ms = 1; bk = 4'd3; wp = 1; end
      end else begin
        ms = 1;
        bk = m_bank;
        wp = !m_conmem && m_mapram && m_bank == 4'd3;
      end
    end
    return {act, rs, ms, bk, wp, m_nmi};
  endfunction

  task automatic check_outs(input string tag);
    check(tag, {7'd0, active, rom_sel, ram_sel, ram_bank, wr_protect, nmi_out},
          {7'd0, exp_out(addr)});
  endtask

  task automatic model_reset();
    m_conmem = 0; m_mapram = 0; m_bank = 0; m_automap = 0; m_pend = 0; m_nmi = 0;
  endtask

  task automatic model_disable();
    m_automap = 0; m_pend = 0;
  endtask

  task automatic model_io(input logic [7:0] d);
    if (en_now()) begin
      m_conmem = d[7];
      m_mapram = m_mapram | d[6];
      m_bank   = d[3:0];
    end
  endtask

  task automatic model_fetch_start(input logic [15:0] a);
    logic entry;
    entry = 0;
    foreach (entries[i]) if (a == entries[i]) entry = 1;
`ifdef DIVMMC_NMI_EN
    if (a == 16'h0066 && !m_nmi) entry = 0;
`endif
    if (en_now()) begin
      if (!m_automap && a[15:8] == 8'h3D) begin
        m_automap = 1; m_pend = 0;
      end else if (!m_automap && m_pend == 0 && entry) begin
        m_pend = 1;
      end else if (m_automap && m_pend == 0 && a >= 16'h1FF8 && a <= 16'h1FFF) begin
        m_pend = -1;
      end
`ifdef DIVMMC_NMI_EN
      if (a == 16'h0066) m_nmi = 0;
`endif
    end
  endtask

  task automatic model_fetch_end();
    if (en_now()) begin
      if (m_pend == 1)  m_automap = 1;
      if (m_pend == -1) m_automap = 0;
    end
    m_pend = 0;
  endtask

  task automatic probe(input logic [15:0] a);
    addr = a;
    #1;
    check_outs("probe");
  endtask

  task automatic io_write(input logic [7:0] hi, input logic [7:0] d);
    addr = {hi, 8'hE3}; din = d; nIORQ = 0; nWR = 0;
    step();
    model_io(d);
    check_outs("io_write");
    nIORQ = 1; nWR = 1;
    step();
  endtask

  task automatic fetch_begin(input logic [15:0] a);
    addr = a; nM1 = 0; nMREQ = 0; nRD = 0;
    step();
    model_fetch_start(a);
    check_outs("fetch_begin");
    step();
    check_outs("fetch_hold");
  endtask

  task automatic fetch_finish();
    nM1 = 1; nMREQ = 1; nRD = 1;
    step();
    model_fetch_end();
    check_outs("fetch_end");
  endtask

  task automatic fetch(input logic [15:0] a);
    fetch_begin(a);
    fetch_finish();
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    reset = 1; enable = 1; mode = 2'b01;
    nWR = 1; nRD = 1; nMREQ = 1; nIORQ = 1; nM1 = 1;
    addr = 0; din = 0; nmi_button = 0;
    model_reset();
    step(); step();
    reset = 0;
    #1;
    check("reset_active", {15'd0, active}, 16'd0);
    check_outs("reset_outs");

    // conmem forces the overlay, ROM writable
    io_write(8'h00, 8'h83);
    probe(16'h0100);
    check("conmem_active", {15'd0, active}, 16'd1);
    check("conmem_rom", {14'd0, rom_sel, wr_protect}, 16'b10);
    probe(16'h2000);
    check("conmem_ram", {11'd0, ram_sel, ram_bank}, {11'd0, 1'b1, 4'd3});
    io_write(8'h00, 8'h00);

    // entry point maps after the fetch, exit range unmaps after the fetch
    fetch_begin(16'h0038);
    check("entry_during", {15'd0, active}, 16'd0);
    fetch_finish();
    check("entry_after", {15'd0, active}, 16'd1);
    fetch_begin(16'h1FF8);
    check("exit_during", {15'd0, active}, 16'd1);
    fetch_finish();
    check("exit_after", {15'd0, active}, 16'd0);

    // instant map, entry while mapped, exit while unmapped
    fetch_begin(16'h3D2F);
    check("instant_during", {15'd0, active}, 16'd1);
    fetch_finish();
    fetch(16'h0000);
    check("entry_while_mapped", {15'd0, active}, 16'd1);
    fetch(16'h1FFF);
    check("exit_1fff", {15'd0, active}, 16'd0);
    fetch(16'h1FF8);
    check("exit_while_unmapped", {15'd0, active}, 16'd0);
    fetch(16'h3CFF);
    check("below_instant", {15'd0, active}, 16'd0);

    // mapram sticky
    io_write(8'h00, 8'h43);
    io_write(8'h00, 8'h00);
    fetch(16'h0000);
    probe(16'h0000);
    check("mapram_low", {10'd0, ram_sel, ram_bank, wr_protect, rom_sel}, {10'd0, 1'b1, 4'd3, 1'b1, 1'b0});
    probe(16'h2000);
    check("mapram_hi", {11'd0, ram_bank, wr_protect}, {11'd0, 4'd0, 1'b0});
    io_write(8'h00, 8'h03);
    probe(16'h3FFF);
    check("bank3_protect", {15'd0, wr_protect}, 16'd1);
    probe(16'h4000);
    check("above_16k", {10'd0, rom_sel, ram_sel, ram_bank, wr_protect}, 16'd0);
    io_write(8'h00, 8'h00);
    fetch(16'h1FF8);

    // reset while a map is pending
    fetch_begin(16'h0000);
    reset = 1;
    step();
    reset = 0;
    model_reset();
    #1;
    check("reset_pend_active", {15'd0, active}, 16'd0);
    check_outs("reset_pend_outs");
    fetch_finish();
    check("reset_pend_after", {15'd0, active}, 16'd0);
    fetch(16'h0008);
    probe(16'h0000);
    check("mapram_cleared", {13'd0, rom_sel, ram_sel, wr_protect}, 16'b101);
    fetch(16'h1FF8);

    // enable low while a map is pending; registers retained
    io_write(8'h00, 8'h05);
    fetch_begin(16'h0000);
    enable = 0;
    step();
    model_disable();
    enable = 1;
    fetch_finish();
    check("disable_pend", {15'd0, active}, 16'd0);
    fetch(16'h3D00);
    probe(16'h2000);
    check("bank_retained", {11'd0, ram_sel, ram_bank}, {11'd0, 1'b1, 4'd5});
    fetch(16'h1FF8);
    enable = 0;
    step();
    model_disable();
    io_write(8'h00, 8'h87);
    enable = 1;
    step();
    probe(16'h0000);
    check("write_ignored", {15'd0, active}, 16'd0);

    // fetch end and port write in the same clock
    addr = 16'h0008; nM1 = 0; nMREQ = 0; nRD = 0;
    step();
    model_fetch_start(16'h0008);
    nM1 = 1; nMREQ = 1; nRD = 1; addr = 16'h00E3; din = 8'h82; nIORQ = 0; nWR = 0;
    step();
    model_fetch_end();
    model_io(8'h82);
    check_outs("combo");
    nIORQ = 1; nWR = 1;
    step();
    io_write(8'h00, 8'h00);
    probe(16'h0000);
    check("combo_mapped", {15'd0, active}, 16'd1);
    fetch(16'h1FF8);

`ifdef DIVMMC_NMI_EN
    fetch(16'h0066);
    check("nmi_ignored", {15'd0, active}, 16'd0);
    nmi_button = 1;
    step();
    m_nmi = 1;
    nmi_button = 0;
    step();
    check("nmi_out_set", {15'd0, nmi_out}, 16'd1);
    fetch_begin(16'h0066);
    check("nmi_cleared", {15'd0, nmi_out}, 16'd0);
    fetch_finish();
    check("nmi_mapped", {15'd0, active}, 16'd1);
    fetch(16'h1FF8);
`endif

    // random traffic
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          d = 8'($urandom);
          d[7] = ($urandom_range(0, 3) == 0);
          io_write(8'($urandom), d);
        end
        2: begin
          enable = ($urandom_range(0, 5) != 0);
          mode = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b01;
          step();
          if (!en_now()) model_disable();
          check_outs("rnd_mode");
        end
        3: begin
          if ($urandom_range(0, 3) == 0) begin
            reset = 1;
            step();
            reset = 0;
            model_reset();
            check_outs("rnd_reset");
          end
        end
        default: begin
          case ($urandom_range(0, 5))
            0: a = entries[$urandom_range(0, 5)];
            1: a = {8'h3D, 8'($urandom)};
            2: a = 16'h1FF8 + 16'($urandom_range(0, 7));
            3: a = 16'h1FF0 + 16'($urandom_range(0, 15));
            4: a = {($urandom_range(0, 1) == 0) ? 8'h3C : 8'h3E, 8'($urandom)};
            default: a = 16'($urandom);
          endcase
          fetch(a);
        end
      endcase
      probe(16'($urandom_range(0, 16'h7FFF)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
